target_spawner: RTL
===================

TARGET_SPAWNER -- requirements
Module: target_spawner

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 640, visible width in pixels.
- V_ACTIVE, 480, visible height in pixels.
- BALL_SIZE, 48, target square edge in pixels.
- TIMEOUT_FRAMES, 60, frames a target stays up before it counts as a miss.
- COOLDOWN_FRAMES, 15, blank frames between targets.
- MAX_MISSES, 5, miss count that ends the game.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, 25 MHz VGA pixel clock; the only clock.
- rst_n, in, 1, reset, synchronous and active-low.
- start, in, 1, level; starts a game from IDLE or GAME_OVER.
- frame_tick, in, 1, one-cycle pulse at the start of vertical blanking.
- hit, in, 1, one-cycle pulse: the player clicked inside the target.
- ballX, out, 10, target left edge, feeding the ball renderer.
- ballY, out, 10, target top edge, feeding the ball renderer.
- ball_visible, out, 1, renderer gates its enable with this.
- score, out, 8, number of hits.
- miss_cnt, out, 8, number of misses.
- game_over, out, 1, high in the GAME_OVER state.

Function
REQ-003 The FSM SHALL have five states: IDLE, SPAWN, ACTIVE, COOLDOWN, GAME_OVER.
REQ-004 A 16-bit Fibonacci LFSR SHALL advance every clk in every state, with taps 16,14,13,11.
REQ-005 IDLE SHALL go to SPAWN on start=1 and clear score, miss_cnt and the frame counter in the same cycle.
REQ-006 SPAWN SHALL wait for frame_tick; on that cycle it SHALL load ballX, ballY, clear the frame counter and enter ACTIVE.
REQ-007 The ballX candidate SHALL be c=lfsr[9:0]; ballX SHALL be c-(H_ACTIVE-BALL_SIZE) if c>=H_ACTIVE-BALL_SIZE (592), else c.
REQ-008 The ballY candidate SHALL be d=lfsr[15:7] zero-extended to 10 bits; ballY SHALL be d-(V_ACTIVE-BALL_SIZE) if d>=V_ACTIVE-BALL_SIZE (432), else d.
REQ-009 Because of REQ-007/008, ballX+BALL_SIZE SHALL be <=H_ACTIVE and ballY+BALL_SIZE SHALL be <=V_ACTIVE at all times.
REQ-010 ballX and ballY SHALL change only on a frame_tick cycle, so no frame is torn.
REQ-011 ball_visible SHALL be 1 only in ACTIVE.
REQ-012 ACTIVE with hit=1 SHALL increment score, saturating at 255, clear the frame counter and enter COOLDOWN on the next cycle.
REQ-013 ACTIVE SHALL increment the frame counter on each frame_tick.
REQ-014 When frame_tick arrives with the counter at TIMEOUT_FRAMES-1, that cycle SHALL be a miss.
REQ-015 A miss SHALL increment miss_cnt (saturating at 255) and clear the frame counter.
REQ-016 After a miss, the FSM SHALL enter GAME_OVER if the new miss_cnt equals MAX_MISSES, else COOLDOWN.
REQ-017 If hit and the timeout frame_tick occur in the same cycle, hit SHALL win: no miss is recorded.
REQ-018 A hit in any state other than ACTIVE SHALL be ignored.
REQ-019 COOLDOWN SHALL count frame_ticks and enter SPAWN on the COOLDOWN_FRAMES-th frame_tick.
REQ-020 GAME_OVER SHALL hold score and miss_cnt and set game_over=1.
REQ-021 GAME_OVER with start=1 SHALL clear score, miss_cnt and the frame counter and enter SPAWN.
REQ-022 start SHALL be ignored in SPAWN, ACTIVE and COOLDOWN.
REQ-023 All outputs SHALL be registered or decoded from the state register, with no combinational path from input to output.
REQ-024 Latency SHALL be one clk from a hit to the updated score or ball_visible=0.

Reset
REQ-025 On a clk edge with rst_n=0, the block SHALL enter IDLE.
REQ-026 That reset SHALL set lfsr=LFSR_SEED, ballX=0, ballY=0, score=0, miss_cnt=0, frame counter=0, ball_visible=0 and game_over=0.
REQ-027 Reset mid-game SHALL abort immediately with no score retained.
REQ-028 rst_n SHALL take priority over every other input.

Verification
REQ-029 Reset, then start=1, then frame_tick -> ACTIVE, ball_visible=1, and ballX/ballY match a reference LFSR model with 0<=ballX<=592 and 0<=ballY<=432.
REQ-030 In ACTIVE, a hit pulse -> score=1 and ball_visible=0 one cycle later; after 15 frame_ticks the block is in SPAWN; the next frame_tick gives a new position.
REQ-031 No hit for 60 frame_ticks -> miss_cnt=1 and COOLDOWN; repeat five times -> game_over=1 with score held.
REQ-032 hit coincident with the 60th frame_tick -> score increments, miss_cnt unchanged.
REQ-033 A hit in COOLDOWN, GAME_OVER or IDLE -> score unchanged; start in ACTIVE -> no effect.
REQ-034 rst_n=0 for one clk while ACTIVE with score=3 -> IDLE, all outputs zero, lfsr=16'hACE1.
REQ-035 A randomized run of 10,000 spawns SHALL never have ballX+48>640 or ballY+48>480.

Source files
------------

// File: rtl/target_spawner.sv
// Whack-a-target game controller: places a square target at pseudo-random
// on-screen positions, times it out over frames, and tallies hits and misses.
module target_spawner #(
  parameter int          H_ACTIVE        = 640,
  parameter int          V_ACTIVE        = 480,
  parameter int          BALL_SIZE       = 48,
  parameter int          TIMEOUT_FRAMES  = 60,
  parameter int          COOLDOWN_FRAMES = 15,
  parameter int          MAX_MISSES      = 5,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [9:0] ballX,
  output logic [9:0] ballY,
  output logic       ball_visible,
  output logic [7:0] score,
  output logic [7:0] miss_cnt,
  output logic       game_over
);

  localparam int CNT_MAX = (TIMEOUT_FRAMES > COOLDOWN_FRAMES) ? TIMEOUT_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [9:0]       X_RANGE      = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0]       Y_RANGE      = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST    = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [7:0]       MISS_LIMIT   = 8'(MAX_MISSES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_ACTIVE,
    S_COOLDOWN,
    S_GAME_OVER
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [9:0]       ball_x_q, ball_x_d;
  logic [9:0]       ball_y_q, ball_y_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       miss_q, miss_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic       lfsr_fb;
  logic [9:0] cand_x, cand_y;
  logic [9:0] spawn_x, spawn_y;
  logic [7:0] score_inc, miss_inc;

  // Taps 16,14,13,11 in 1-based numbering.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // A single conditional subtract folds each candidate into the legal range,
  // since neither candidate can reach twice its range.
  assign cand_x  = lfsr_q[9:0];
  assign cand_y  = {1'b0, lfsr_q[15:7]};
  assign spawn_x = (cand_x >= X_RANGE) ? (cand_x - X_RANGE) : cand_x;
  assign spawn_y = (cand_y >= Y_RANGE) ? (cand_y - Y_RANGE) : cand_y;

  assign score_inc = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
  assign miss_inc  = (miss_q == 8'hFF) ? miss_q : miss_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    lfsr_d      = {lfsr_q[14:0], lfsr_fb};
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    score_d     = score_q;
    miss_d      = miss_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          score_d     = 8'd0;
          miss_d      = 8'd0;
          frame_cnt_d = '0;
          state_d     = S_SPAWN;
        end
      end
      S_SPAWN: begin
        if (frame_tick) begin
          ball_x_d    = spawn_x;
          ball_y_d    = spawn_y;
          frame_cnt_d = '0;
          state_d     = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // A hit outranks a simultaneous timeout tick.
        if (hit) begin
          score_d     = score_inc;
          frame_cnt_d = '0;
          state_d     = S_COOLDOWN;
        end else if (frame_tick) begin
          if (frame_cnt_q == TIMEOUT_LAST) begin
            miss_d      = miss_inc;
            frame_cnt_d = '0;
            state_d     = (miss_inc == MISS_LIMIT) ? S_GAME_OVER : S_COOLDOWN;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_COOLDOWN: begin
        if (frame_tick) begin
          if (frame_cnt_q == COOL_LAST) begin
            frame_cnt_d = '0;
            state_d     = S_SPAWN;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      ball_x_q    <= 10'd0;
      ball_y_q    <= 10'd0;
      score_q     <= 8'd0;
      miss_q      <= 8'd0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      score_q     <= score_d;
      miss_q      <= miss_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign ballX        = ball_x_q;
  assign ballY        = ball_y_q;
  assign score        = score_q;
  assign miss_cnt     = miss_q;
  assign ball_visible = (state_q == S_ACTIVE);
  assign game_over    = (state_q == S_GAME_OVER);

endmodule
